// File: rtl/pipeline_control_irq_pkg.sv
// Shared types and constants for the IRQ entry dispatcher.
package pipeline_control_irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_FLAGS,
        ST_WAIT_FLAGS,
        ST_REQ_HDL,
        ST_WAIT_HDL,
        ST_DONE
    } irq_state_t;

    localparam int          IRQ_FLAG_VALID_BIT  = 0;
    localparam logic [1:0]  LDST_ORDER_WORD     = 2'b10;
    localparam logic [31:0] IRQ_HDL_WORD_OFFSET = 32'd4;

endpackage

// File: rtl/pipeline_control_irq_hundler_cache.sv
// Direct-mapped handler cache for the IRQ dispatcher (MIST32_IRQ_HUNDLER_CACHE_EN builds only).
// Any change of the IDT base invalidates every entry.
module pipeline_control_irq_hundler_cache
    import pipeline_control_irq_pkg::*;
#(
    parameter int IRQ_NUM_W   = 7,
    parameter int CACHE_DEPTH = 4
)(
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iFLUSH,
    input  logic [31:0]          iIDTR,
    input  logic [IRQ_NUM_W-1:0] iLOOKUP_NUM,
    output logic                 oHIT,
    output logic [31:0]          oHIT_HDL,
    input  logic                 iFILL,
    input  logic [IRQ_NUM_W-1:0] iFILL_NUM,
    input  logic [31:0]          iFILL_HDL
);
    localparam int IDX_W = $clog2(CACHE_DEPTH);

    logic [CACHE_DEPTH-1:0] r_vld;
    logic [IRQ_NUM_W-1:0]   r_tag  [CACHE_DEPTH];
    logic [31:0]            r_data [CACHE_DEPTH];
    logic [31:0]            r_prev_idtr;

    logic                   w_idtr_chg;
    logic                   w_flush;
    logic [IDX_W-1:0]       w_lk_idx;
    logic [IDX_W-1:0]       w_fill_idx;

    assign w_idtr_chg = (iIDTR != r_prev_idtr);
    assign w_flush    = iFLUSH | w_idtr_chg;
    assign w_lk_idx   = iLOOKUP_NUM[IDX_W-1:0];
    assign w_fill_idx = iFILL_NUM[IDX_W-1:0];

    // A hit is suppressed in a flush cycle so a stale entry never escapes.
    assign oHIT     = r_vld[w_lk_idx] && (r_tag[w_lk_idx] == iLOOKUP_NUM) && !w_flush;
    assign oHIT_HDL = r_data[w_lk_idx];

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_vld       <= '0;
            r_prev_idtr <= '0;
        end else begin
            r_prev_idtr <= iIDTR;
            if (w_flush)
                r_vld <= '0;
            else if (iFILL)
                r_vld[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iFILL) begin
            r_tag[w_fill_idx]  <= iFILL_NUM;
            r_data[w_fill_idx] <= iFILL_HDL;
        end
    end

endmodule

// File: rtl/pipeline_control_irq_dispatch.sv
// IRQ entry dispatcher: reads flags then handler word of an IDT entry over the LDST port.
// Optional handler cache enabled by defining MIST32_IRQ_HUNDLER_CACHE_EN.
module pipeline_control_irq_dispatch
    import pipeline_control_irq_pkg::*;
#(
    parameter int IRQ_NUM_W       = 7,
    parameter int IDT_ENTRY_BYTES = 8,
    parameter int CACHE_DEPTH     = 4
)(
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iRESET_SYNC,
    input  logic [31:0]          iSYSREG_IDTR,
    input  logic                 iIRQ_START,
    input  logic [IRQ_NUM_W-1:0] iIRQ_NUM,
    input  logic                 iCACHE_FLUSH,
    output logic                 oBUSY,
    output logic                 oFINISH,
    output logic                 oFINISH_VALID,
    output logic [31:0]          oFINISH_HUNDLER,
    output logic                 oLDST_USE,
    output logic                 oLDST_REQ,
    input  logic                 iLDST_BUSY,
    output logic [1:0]           oLDST_ORDER,
    output logic                 oLDST_RW,
    output logic [31:0]          oLDST_ADDR,
    output logic [31:0]          oLDST_DATA,
    input  logic                 iLDST_REQ,
    input  logic [31:0]          iLDST_DATA
);
    localparam int ENT_SHIFT = $clog2(IDT_ENTRY_BYTES);

    irq_state_t           r_state, w_next;
    logic [31:0]          r_idtr;
    logic [IRQ_NUM_W-1:0] r_num;
    logic                 r_finish;
    logic                 r_valid;
    logic [31:0]          r_hdl;
    logic                 r_discard;

    logic                 w_start_ok;
    logic                 w_hit;
    logic [31:0]          w_hit_hdl;
    logic                 w_outstanding;
    logic [31:0]          w_base;
    logic                 w_flags_ok;

    assign w_start_ok = (r_state == ST_IDLE) && iIRQ_START && !r_discard;
    assign w_base     = r_idtr + (32'(r_num) << ENT_SHIFT);
    assign w_flags_ok = iLDST_DATA[IRQ_FLAG_VALID_BIT];

    // A load is in flight if it is accepted this cycle or awaited without data now.
    assign w_outstanding = ((r_state == ST_REQ_FLAGS || r_state == ST_REQ_HDL) && !iLDST_BUSY) ||
                           ((r_state == ST_WAIT_FLAGS || r_state == ST_WAIT_HDL) && !iLDST_REQ);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_start_ok) w_next = w_hit ? ST_DONE : ST_REQ_FLAGS;
            ST_REQ_FLAGS:  if (!iLDST_BUSY) w_next = ST_WAIT_FLAGS;
            ST_WAIT_FLAGS: if (iLDST_REQ) w_next = w_flags_ok ? ST_REQ_HDL : ST_DONE;
            ST_REQ_HDL:    if (!iLDST_BUSY) w_next = ST_WAIT_HDL;
            ST_WAIT_HDL:   if (iLDST_REQ) w_next = ST_DONE;
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
        if (iRESET_SYNC)
            w_next = ST_IDLE;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            r_discard <= 1'b0;
        else if (iRESET_SYNC && w_outstanding)
            r_discard <= 1'b1;
        else if (r_discard && iLDST_REQ)
            r_discard <= 1'b0;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_idtr   <= '0;
            r_num    <= '0;
            r_finish <= 1'b0;
            r_valid  <= 1'b0;
            r_hdl    <= '0;
        end else begin
            r_finish <= (w_next == ST_DONE);
            if (iRESET_SYNC) begin
                r_valid <= 1'b0;
                r_hdl   <= '0;
            end else if (w_start_ok) begin
                r_idtr <= iSYSREG_IDTR;
                r_num  <= iIRQ_NUM;
                if (w_hit) begin
                    r_valid <= 1'b1;
                    r_hdl   <= w_hit_hdl;
                end
            end else if (r_state == ST_WAIT_FLAGS && iLDST_REQ && !w_flags_ok) begin
                r_valid <= 1'b0;
                r_hdl   <= '0;
            end else if (r_state == ST_WAIT_HDL && iLDST_REQ) begin
                r_valid <= 1'b1;
                r_hdl   <= iLDST_DATA;
            end
        end
    end

`ifdef MIST32_IRQ_HUNDLER_CACHE_EN
    logic w_fill;
    // Skip the fill if the table base moved while the entry was being read.
    assign w_fill = (r_state == ST_WAIT_HDL) && iLDST_REQ && !iRESET_SYNC &&
                    (r_idtr == iSYSREG_IDTR);

    pipeline_control_irq_hundler_cache #(
        .IRQ_NUM_W   (IRQ_NUM_W),
        .CACHE_DEPTH (CACHE_DEPTH)
    ) u_cache (
        .iCLOCK      (iCLOCK),
        .iRESET      (iRESET),
        .iFLUSH      (iCACHE_FLUSH | iRESET_SYNC),
        .iIDTR       (iSYSREG_IDTR),
        .iLOOKUP_NUM (iIRQ_NUM),
        .oHIT        (w_hit),
        .oHIT_HDL    (w_hit_hdl),
        .iFILL       (w_fill),
        .iFILL_NUM   (r_num),
        .iFILL_HDL   (iLDST_DATA)
    );
`else
    logic w_unused_flush;
    assign w_unused_flush = iCACHE_FLUSH;
    assign w_hit          = 1'b0;
    assign w_hit_hdl      = '0;
`endif

    assign oBUSY           = (r_state != ST_IDLE);
    assign oLDST_USE       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign oLDST_REQ       = (r_state == ST_REQ_FLAGS) || (r_state == ST_REQ_HDL);
    assign oLDST_ADDR      = (r_state == ST_REQ_FLAGS || r_state == ST_WAIT_FLAGS) ? w_base :
                             (r_state == ST_REQ_HDL   || r_state == ST_WAIT_HDL)   ?
                             w_base + IRQ_HDL_WORD_OFFSET : 32'd0;
    assign oLDST_ORDER     = LDST_ORDER_WORD;
    assign oLDST_RW        = 1'b0;
    assign oLDST_DATA      = 32'd0;
    assign oFINISH         = r_finish;
    assign oFINISH_VALID   = r_valid;
    assign oFINISH_HUNDLER = r_hdl;

endmodule

// File: tb/tb_pipeline_control_irq_dispatch.sv
// Directed bench for the IRQ entry dispatcher; the LDST responder answers one cycle after accept.
module tb_pipeline_control_irq_dispatch;

    logic        iCLOCK, iRESET, iRESET_SYNC, iIRQ_START, iCACHE_FLUSH;
    logic [31:0] iSYSREG_IDTR;
    logic [6:0]  iIRQ_NUM;
    logic        iLDST_BUSY, iLDST_REQ;
    logic [31:0] iLDST_DATA;
    logic        oBUSY, oFINISH, oFINISH_VALID, oLDST_USE, oLDST_REQ, oLDST_RW;
    logic [31:0] oFINISH_HUNDLER, oLDST_ADDR, oLDST_DATA;
    logic [1:0]  oLDST_ORDER;

    pipeline_control_irq_dispatch #(.IRQ_NUM_W(7), .IDT_ENTRY_BYTES(8), .CACHE_DEPTH(4)) dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
        .iSYSREG_IDTR(iSYSREG_IDTR), .iIRQ_START(iIRQ_START), .iIRQ_NUM(iIRQ_NUM),
        .iCACHE_FLUSH(iCACHE_FLUSH), .oBUSY(oBUSY), .oFINISH(oFINISH),
        .oFINISH_VALID(oFINISH_VALID), .oFINISH_HUNDLER(oFINISH_HUNDLER),
        .oLDST_USE(oLDST_USE), .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY),
        .oLDST_ORDER(oLDST_ORDER), .oLDST_RW(oLDST_RW), .oLDST_ADDR(oLDST_ADDR),
        .oLDST_DATA(oLDST_DATA), .iLDST_REQ(iLDST_REQ), .iLDST_DATA(iLDST_DATA)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int          cyc, T, n_chk, n_pass, nlog, stall_left;
    logic [31:0] log_addr [8];
    logic [31:0] m_faddr, m_fval, m_haddr, m_hval;
    bit          hold_resp, fin_seen, use_seen;
    int          fin_cyc;
    logic        fin_valid, fin_use;
    logic [31:0] fin_hdl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: sample at negedge, then drive responses/stalls 1ns after posedge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge iCLOCK);
        acc = oLDST_REQ && !iLDST_BUSY;
        a   = oLDST_ADDR;
        if (acc && nlog < 8) begin
            log_addr[nlog] = a;
            nlog++;
        end
        if (oLDST_USE) use_seen = 1;
        if (oFINISH && !fin_seen) begin
            fin_seen  = 1;
            fin_cyc   = cyc;
            fin_valid = oFINISH_VALID;
            fin_hdl   = oFINISH_HUNDLER;
            fin_use   = oLDST_USE;
        end
        @(posedge iCLOCK);
        #1;
        cyc++;
        iLDST_REQ  = acc && !hold_resp;
        iLDST_DATA = !acc ? 32'h0 : (a == m_faddr) ? m_fval : (a == m_haddr) ? m_hval : 32'hBAD0_0BAD;
        if (stall_left > 0 && oLDST_REQ) begin
            iLDST_BUSY = 1'b1;
            stall_left--;
            chk("stall_addr_held", oLDST_ADDR, m_faddr);
        end else begin
            iLDST_BUSY = 1'b0;
        end
    endtask

    task automatic run_irq(input logic [31:0] idtr, input logic [6:0] num,
                           input logic [31:0] fa, input logic [31:0] fv,
                           input logic [31:0] ha, input logic [31:0] hv, input int stalls);
        iSYSREG_IDTR = idtr;
        m_faddr = fa; m_fval = fv; m_haddr = ha; m_hval = hv;
        tick(); tick();
        stall_left = stalls;
        nlog = 0; fin_seen = 0; use_seen = 0;
        iIRQ_NUM = num; iIRQ_START = 1'b1; T = cyc;
        tick();
        iIRQ_START = 1'b0;
        for (int i = 0; i < 30 && !fin_seen; i++) tick();
        chk("finish_seen", 32'(fin_seen), 32'd1);
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0; nlog = 0; stall_left = 0;
        hold_resp = 0; fin_seen = 0; use_seen = 0; fin_cyc = 0;
        iRESET = 1'b1; iRESET_SYNC = 1'b0; iIRQ_START = 1'b0; iCACHE_FLUSH = 1'b0;
        iSYSREG_IDTR = 32'h0; iIRQ_NUM = '0; iLDST_BUSY = 1'b0; iLDST_REQ = 1'b0; iLDST_DATA = '0;
        m_faddr = '1; m_fval = '0; m_haddr = '1; m_hval = '0;
        tick(); tick();
        chk("rst_busy",   32'(oBUSY), 32'd0);
        chk("rst_finish", 32'(oFINISH), 32'd0);
        chk("rst_valid",  32'(oFINISH_VALID), 32'd0);
        chk("rst_hdl",    oFINISH_HUNDLER, 32'd0);
        chk("rst_use",    32'(oLDST_USE), 32'd0);
        chk("rst_req",    32'(oLDST_REQ), 32'd0);
        chk("rst_addr",   oLDST_ADDR, 32'd0);
        chk("rst_order",  32'(oLDST_ORDER), 32'd2);
        chk("rst_rw",     32'(oLDST_RW), 32'd0);
        chk("rst_data",   oLDST_DATA, 32'd0);
        iRESET = 1'b0;

        // Valid entry, no stall
        run_irq(32'h0000_1000, 7'd5, 32'h1028, 32'h1, 32'h102C, 32'h0000_8000, 0);
        chk("v_lat",   32'(fin_cyc - T), 32'd5);
        chk("v_valid", 32'(fin_valid), 32'd1);
        chk("v_hdl",   fin_hdl, 32'h0000_8000);
        chk("v_nreq",  32'(nlog), 32'd2);
        chk("v_addr0", log_addr[0], 32'h1028);
        chk("v_addr1", log_addr[1], 32'h102C);
        chk("v_use_at_done", 32'(fin_use), 32'd0);

        // Invalid entry: single read, early finish
        run_irq(32'h0000_1000, 7'd3, 32'h1018, 32'h0, 32'h101C, 32'h1234_5678, 0);
        chk("inv_lat",   32'(fin_cyc - T), 32'd3);
        chk("inv_valid", 32'(fin_valid), 32'd0);
        chk("inv_hdl",   fin_hdl, 32'd0);
        chk("inv_nreq",  32'(nlog), 32'd1);
        chk("inv_addr0", log_addr[0], 32'h1018);

        // Four stall cycles on the flags request
        run_irq(32'h0000_2000, 7'd5, 32'h2028, 32'h1, 32'h202C, 32'h0000_4444, 4);
        chk("st_lat",  32'(fin_cyc - T), 32'd9);
        chk("st_hdl",  fin_hdl, 32'h0000_4444);
        chk("st_nreq", 32'(nlog), 32'd2);

        // Address wrap-around at the top of memory
        run_irq(32'hFFFF_FFF8, 7'd0, 32'hFFFF_FFF8, 32'h3, 32'hFFFF_FFFC, 32'hAAAA_0000, 0);
        chk("w0_addr0", log_addr[0], 32'hFFFF_FFF8);
        chk("w0_addr1", log_addr[1], 32'hFFFF_FFFC);
        chk("w0_hdl",   fin_hdl, 32'hAAAA_0000);
        run_irq(32'hFFFF_FFF8, 7'd1, 32'h0, 32'h1, 32'h4, 32'h0000_5555, 0);
        chk("w1_addr0", log_addr[0], 32'h0);
        chk("w1_addr1", log_addr[1], 32'h4);
        chk("w1_hdl",   fin_hdl, 32'h0000_5555);

        // Sync reset with a handler load in flight, then a stale response
        iSYSREG_IDTR = 32'h0000_1000;
        m_faddr = 32'h1028; m_fval = 32'h1; m_haddr = 32'h102C; m_hval = 32'h0000_8000;
        tick(); tick();
        hold_resp = 1; nlog = 0; fin_seen = 0;
        iIRQ_NUM = 7'd5; iIRQ_START = 1'b1; tick(); iIRQ_START = 1'b0;
        tick();
        iLDST_REQ = 1'b1; iLDST_DATA = 32'h1; tick();
        iLDST_REQ = 1'b0; iLDST_DATA = 32'h0;
        tick();
        chk("rs_in_wait_hdl", oLDST_ADDR, 32'h102C);
        chk("rs_nreq", 32'(nlog), 32'd2);
        iRESET_SYNC = 1'b1; tick(); iRESET_SYNC = 1'b0;
        chk("rs_idle", 32'(oBUSY), 32'd0);
        chk("rs_req",  32'(oLDST_REQ), 32'd0);
        iIRQ_START = 1'b1; tick(); iIRQ_START = 1'b0;
        chk("rs_start_held_off", 32'(oBUSY), 32'd0);
        iLDST_REQ = 1'b1; iLDST_DATA = 32'hDEAD_BEEF; tick();
        iLDST_REQ = 1'b0; iLDST_DATA = 32'h0;
        chk("rs_no_finish", 32'(fin_seen), 32'd0);
        chk("rs_still_idle", 32'(oBUSY), 32'd0);
        hold_resp = 0;
        run_irq(32'h0000_1000, 7'd5, 32'h1028, 32'h1, 32'h102C, 32'h0000_8000, 0);
        chk("rs_after_lat", 32'(fin_cyc - T), 32'd5);
        chk("rs_after_hdl", fin_hdl, 32'h0000_8000);
        chk("rs_after_valid", 32'(fin_valid), 32'd1);

`ifdef MIST32_IRQ_HUNDLER_CACHE_EN
        run_irq(32'h0000_3000, 7'd2, 32'h3010, 32'h1, 32'h3014, 32'h0000_7777, 0);
        chk("c_miss_lat", 32'(fin_cyc - T), 32'd5);
        run_irq(32'h0000_3000, 7'd2, 32'h3010, 32'h1, 32'h3014, 32'h0000_7777, 0);
        chk("c_hit_lat",  32'(fin_cyc - T), 32'd1);
        chk("c_hit_hdl",  fin_hdl, 32'h0000_7777);
        chk("c_hit_nreq", 32'(nlog), 32'd0);
        chk("c_hit_use",  32'(use_seen), 32'd0);
        iCACHE_FLUSH = 1'b1; tick(); iCACHE_FLUSH = 1'b0;
        run_irq(32'h0000_3000, 7'd2, 32'h3010, 32'h1, 32'h3014, 32'h0000_7777, 0);
        chk("c_flush_lat", 32'(fin_cyc - T), 32'd5);
        iSYSREG_IDTR = 32'h0000_3100; tick();
        run_irq(32'h0000_3000, 7'd2, 32'h3010, 32'h1, 32'h3014, 32'h0000_7777, 0);
        chk("c_idtr_lat", 32'(fin_cyc - T), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_control_irq_dispatch.md
Name: pipeline_control_irq_dispatch

Overview:
- Parametrised IRQ entry dispatcher in pipeline_control. On an IRQ request it reads a multi-word IDT entry (flags word, then handler word) through the shared load/store port.
- It validates the entry and returns the handler address, or an invalid-entry indication, to the pipeline controller.
- It generalises the single-word handler fetch with a configurable IRQ number width, configurable entry stride and a valid-bit check.
- It adds safe discard of in-flight loads after a sync reset, plus an optional handler cache.

Parameters:
- IRQ_NUM_W, 7, width of the IRQ number; table holds 2**IRQ_NUM_W entries.
- IDT_ENTRY_BYTES, 8, entry stride in bytes; power of two, >= 8.
- CACHE_DEPTH, 4, handler cache entries (power of two); only used with the optional feature.

Ports:
- iCLOCK  in  1  clock.
- iRESET  in  1  asynchronous, active-high reset.
- iRESET_SYNC  in  1  synchronous reset; same effect as iRESET except as noted.
- iSYSREG_IDTR  in  32  IDT base byte address.
- iIRQ_START  in  1  start pulse; sampled only in IDLE.
- iIRQ_NUM  in  IRQ_NUM_W  IRQ number; captured with iIRQ_START.
- iCACHE_FLUSH  in  1  invalidates the cache; ignored when the feature is off.
- oBUSY  out  1  state != IDLE.
- oFINISH  out  1  registered one-cycle done pulse.
- oFINISH_VALID  out  1  entry valid bit; meaningful with oFINISH.
- oFINISH_HUNDLER  out  32  handler address; 0 when the entry is invalid.
- oLDST_USE  out  1  port owned (state != IDLE and != DONE).
- oLDST_REQ  out  1  load request level.
- iLDST_BUSY  in  1  port stall.
- oLDST_ORDER  out  2  always 2'b10 (word).
- oLDST_RW  out  1  always 0 (read).
- oLDST_ADDR  out  32  request address.
- oLDST_DATA  out  32  always 0.
- iLDST_REQ  in  1  read data valid.
- iLDST_DATA  in  32  read data.

Behaviour:
- Reset values: all outputs 0 except oLDST_ORDER = 2'b10. State is IDLE.
- Entry address: base = iSYSREG_IDTR + (num << log2(IDT_ENTRY_BYTES)), 32-bit wrap-around.
  - Flags word at base; handler word at base + 4, also wrapping.
  - IDTR is sampled at START and held in a register.
- Entry format: flags bit0 = valid; other flag bits are ignored by this block.
- FSM states: IDLE, REQ_FLAGS, WAIT_FLAGS, REQ_HDL, WAIT_HDL, DONE.
  - IDLE -> REQ_FLAGS on iIRQ_START (cache hit: IDLE -> DONE).
  - REQ_FLAGS: oLDST_REQ = 1. Go to WAIT_FLAGS in the cycle iLDST_BUSY = 0 (request accepted).
  - WAIT_FLAGS: on iLDST_REQ, latch flags. Valid -> REQ_HDL; invalid -> DONE with VALID = 0 and HUNDLER = 0, skipping the handler read.
  - REQ_HDL and WAIT_HDL follow the same handshake as REQ_FLAGS and WAIT_FLAGS; on iLDST_REQ latch the handler -> DONE.
  - DONE: oFINISH = 1 for exactly 1 cycle -> IDLE.
- Handshake rules:
  - oLDST_REQ and oLDST_ADDR stay stable while iLDST_BUSY = 1.
  - At most one load outstanding.
  - iLDST_REQ outside WAIT_* is ignored.
- Latency, zero stall, response 1 cycle after accept, START at cycle T: flags request at T+1, flags data at T+2, handler request at T+3, handler data at T+4, oFINISH at T+5.
- iIRQ_START while oBUSY = 1 is ignored and not queued. A START arriving in the same cycle as DONE is also ignored.
- iRESET_SYNC mid-operation: go to IDLE and drop oLDST_REQ at the next edge.
  - If a request was accepted with no response yet, set a discard flag. The next iLDST_REQ is dropped and the flag clears.
  - While the discard flag is set, new START requests are held off (IDLE, START ignored).
  - iRESET clears the discard flag unconditionally.

Optional Feature:
- Macro: MIST32_IRQ_HUNDLER_CACHE_EN.
- With the macro defined:
  - CACHE_DEPTH-entry direct-mapped cache, index = num[log2(CACHE_DEPTH)-1:0], tag = full num. Only valid entries are cached.
  - Hit in IDLE: go straight to DONE, oFINISH at T+1, no LDST activity.
  - Fill on handler capture.
  - Full invalidate on iCACHE_FLUSH, iRESET_SYNC, iRESET, or any change of iSYSREG_IDTR from its previous-cycle value.
  - A flush arriving in the same cycle as a fill wins.
- Without the macro: no cache storage; iCACHE_FLUSH is unconnected internally; every IRQ performs memory reads.

Decomposition:
- Package pipeline_control_irq_pkg holds:
  - the state enum;
  - IRQ_FLAG_VALID_BIT = 0;
  - LDST_ORDER_WORD = 2'b10;
  - IRQ_HDL_WORD_OFFSET = 4.
- One sub-module: pipeline_control_irq_hundler_cache, instantiated only under the macro. Its interface is lookup, fill, flush, IDTR-change detect.

Test Plan:
- IDTR = 0x0000_1000, num = 5, flags = 1, handler = 0x0000_8000, no stalls -> reads at 0x1028 then 0x102C; oFINISH at T+5 with VALID = 1 and HUNDLER = 0x8000.
- Flags = 0 for num = 3 -> single read at IDTR + 0x18; oFINISH at T+3 with VALID = 0 and HUNDLER = 0; no second request.
- iLDST_BUSY high for 4 cycles in REQ_FLAGS -> oLDST_REQ and ADDR held; finish delayed by exactly 4 cycles.
- IDTR = 0xFFFF_FFF8, num = 0 -> flags read at 0xFFFF_FFF8, handler read at 0xFFFF_FFFC; with num = 1, addresses wrap to 0x0 and 0x4.
- iRESET_SYNC during WAIT_HDL, stale response 2 cycles later with data 0xDEAD_BEEF -> response discarded; a following START completes with the correct handler; START during the discard window is ignored.
- Cache on: second IRQ 5 -> oFINISH at T+1, oLDST_USE stays 0. After an IDTR write or iCACHE_FLUSH -> full memory read again.
